// File: rtl/instr_encoder_loader.sv
// Boot-time program loader: packs instruction descriptors into RV32 words
// and streams them into instruction memory at consecutive byte addresses.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpFload  = 7'b0000111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpFstore = 7'b0100111;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpFpR    = 7'b1010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpAluI   = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpStall  = 7'b0000000;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;       // address for the next accepted descriptor
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;

  logic                accept;
  logic                wr_fire;
  logic [31:0]         enc_word;
  logic                enc_err;
  logic signed [31:0]  imm_s;

  assign imm_s = in_imm;

  // Combinational encoder; any error replaces the word with zero.
  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (in_op)
      OpLoad, OpFload, OpAluI: begin
        enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
      end
      OpStore, OpFstore: begin
        enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
      end
      OpBranch: begin
        enc_err  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                    in_imm[4:1], in_imm[11], in_op};
      end
      OpJal: begin
        enc_err  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
      end
      OpLui: begin
        enc_err  = (in_imm[11:0] != 12'h000);
        enc_word = {in_imm[31:12], in_rd, in_op};
      end
      OpRtype, OpFpR: begin
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
      end
      OpStall: enc_word = '0;
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_word = '0;
  end

  // One-entry output register: accept whenever it is empty or draining this cycle.
  assign in_ready = (state_q == StLoad) && (remaining_q != '0) && (!we_q || imem_ready);
  assign accept   = in_valid && in_ready;
  assign wr_fire  = we_q && imem_ready;

  // Next-state, datapath and session bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    we_d        = we_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    err_count_d = err_count_q;

    if (wr_fire) we_d = 1'b0;
    if (accept) begin
      we_d        = 1'b1;
      waddr_d     = addr_q;
      wdata_d     = enc_word;
      addr_d      = addr_q + ADDR_W'(4);
      remaining_d = remaining_q - CNT_W'(1);
      if (enc_err) begin
        err_d = 1'b1;
        if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + CNT_W'(1);
      end
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          addr_d      = {base_addr[ADDR_W-1:2], 2'b00};
          remaining_d = word_count;
          err_d       = 1'b0;
          err_count_d = '0;
          state_d     = (word_count == '0) ? StDone : StLoad;
        end
      end
      StLoad:  if (accept && remaining_q == CNT_W'(1)) state_d = StDrain;
      StDrain: if (wr_fire) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == StLoad) || (state_q == StDrain);
  assign done       = (state_q == StDone);
  assign err        = err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: directed scenarios plus random sessions
// checked against an arithmetic encoding model.
`timescale 1ns/1ps
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready;
  logic        busy, done, err;
  logic [15:0] err_count;

  instr_encoder_loader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .busy(busy), .done(done), .err(err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];       // {addr, word}
  logic [31:0] exp_addr;
  int          exp_errs;
  int          ready_mode = 0; // 0: always ready, 1: random, 2: never ready

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  // Reference encoding from the field layouts, done with shifts and masks.
  function automatic logic [32:0] model_encode(input int unsigned op, input int unsigned rd,
      input int unsigned rs1, input int unsigned rs2, input int unsigned f3,
      input int unsigned f7, input int imm);
    int unsigned u = imm;
    int unsigned w = 0;
    bit bad = 0;
    case (op)
      3, 7, 19: begin
        bad = (imm < -2048) || (imm > 2047);
        w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((u & 32'hfff) << 20);
      end
      35, 39: begin
        bad = (imm < -2048) || (imm > 2047);
        w = op + ((u & 31) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20)
            + (((u >> 5) & 127) << 25);
      end
      99: begin
        bad = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
        w = op + (((u >> 11) & 1) << 7) + (((u >> 1) & 15) << 8) + (rs1 << 15)
            + (rs2 << 20) + (((u >> 5) & 63) << 25) + (((u >> 12) & 1) << 31);
      end
      111: begin
        bad = (imm < -1048576) || (imm > 1048574) || (imm % 2 != 0);
        w = op + (rd << 7) + (((u >> 12) & 255) << 12) + (((u >> 11) & 1) << 20)
            + (((u >> 1) & 1023) << 21) + (((u >> 20) & 1) << 31);
      end
      55: begin
        bad = (u % 4096) != 0;
        w = op + (rd << 7) + (u & 32'hfffff000);
      end
      51, 83: w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7 << 25);
      0: w = 0;
      default: bad = 1;
    endcase
    if (bad) w = 0;
    return {bad, w};
  endfunction

  // Imem back-pressure generator.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: imem_ready = 1'b1;
      1: imem_ready = ($urandom_range(0, 3) != 0);
      default: imem_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every completed write and checks output hold.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_we", {31'd0, imem_we}, 32'd1);
        check("hold_addr", imem_addr, prev_addr);
        check("hold_data", imem_wdata, prev_data);
      end
      if (imem_we && imem_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h want no write",
                   imem_addr, imem_wdata);
        end else begin
          logic [63:0] e;
          e = sb_q.pop_front();
          check("write_addr", imem_addr, e[63:32]);
          check("write_data", imem_wdata, e[31:0]);
        end
      end
      prev_stall = imem_we && !imem_ready;
      prev_addr  = imem_addr;
      prev_data  = imem_wdata;
    end
  end

  task automatic start_session(input logic [31:0] base, input logic [15:0] cnt);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; word_count = cnt;
    exp_addr = base & ~32'd3;
    exp_errs = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents one descriptor (caller is at posedge+1) and returns after acceptance.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input logic [31:0] exp_w, input bit bad, output int waited);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) break;
    end
    if (waited > 200) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      sb_q.push_back({exp_addr, exp_w});
      exp_addr += 32'd4;
      if (bad) exp_errs++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_session(input string tag);
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_errs != 0});
    check({tag, "_err_count"}, {16'd0, err_count}, exp_errs);
    check({tag, "_pending"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    int w;
    int wsum;
    logic [6:0] ops [12];
    int edges [11];
    ops   = '{7'h03, 7'h07, 7'h23, 7'h27, 7'h33, 7'h53, 7'h63, 7'h13, 7'h6f, 7'h37,
              7'h00, 7'h7f};
    edges = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -1048576, 1048574, 1048576,
              32'h12345000};

    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0;
    in_imm = '0; imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_count", {16'd0, err_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);

    // Single R-type add; done follows the accepted write by one cycle.
    start_session(32'h100, 16'd1);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 0, w);
    wsum = 0;
    while (sb_q.size() != 0 && wsum < 50) begin
      @(negedge clk); #1;
      wsum++;
    end
    check("t1_done_at_write", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("t1_done_after", {31'd0, done}, 32'd1);
    finish_session("t1");

    // lw / sw / lui back to back with no stalls.
    start_session(32'h100, 16'd3);
    wsum = 0;
    send(7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8, 32'h00812283, 0, w); wsum += w;
    send(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd12, 32'h00512623, 0, w); wsum += w;
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 0, w); wsum += w;
    check("t2_no_backpressure", wsum, 32'd0);
    finish_session("t2");

    // beq then jal with the first write stalled for three cycles.
    ready_mode = 2;
    start_session(32'h100, 16'd2);
    fork
      begin
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd5, 7'd0, -32'sd8, 32'hFE208CE3, 0, w);
        send(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 32'h010000EF, 0, w);
      end
      begin
        int k;
        k = 0;
        while (!imem_we && k < 20) begin
          @(negedge clk);
          k++;
        end
        for (int i = 0; i < 3; i++) begin
          check("t3_in_ready_stalled", {31'd0, in_ready}, 32'd0);
          if (i < 2) @(negedge clk);
        end
        ready_mode = 0;
      end
    join
    finish_session("t3");

    // Encode errors still produce zero words at consecutive addresses.
    start_session(32'h180, 16'd3);
    send(7'h7f, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'h0, 1, w);
    send(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h0, 1, w);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h0, 1, w);
    finish_session("t4");

    // Reset while a write is pending aborts the session immediately.
    ready_mode = 2;
    start_session(32'h300, 16'd2);
    send(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 32'h003100B3, 0, w);
    #2;
    check("t5_we_before_reset", {31'd0, imem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_we", {31'd0, imem_we}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_done", {31'd0, done}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    ready_mode = 0;
    start_session(32'h400, 16'd0);
    @(negedge clk);
    check("t5_zero_count_done", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
    finish_session("t5");

    // A start pulse during LOAD must not disturb the session.
    start_session(32'h200, 16'd3);
    send(7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00120213, 0, w);
    start = 1'b1; base_addr = 32'h900; word_count = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("t6_busy_after_restart", {31'd0, busy}, 32'd1);
    send(7'h13, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00220213, 0, w);
    send(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0, 0, w);
    finish_session("t6");

    // Random sessions with back-pressure; one base near the top of memory to wrap.
    ready_mode = 1;
    for (int s = 0; s < 6; s++) begin
      logic [31:0] base;
      int cnt;
      base = (s == 5) ? 32'hFFFFFFF2 : $urandom;
      cnt  = $urandom_range(1, 20);
      start_session(base, cnt[15:0]);
      for (int i = 0; i < cnt; i++) begin
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          imm;
        logic [32:0] m;
        op  = ops[$urandom_range(0, 11)];
        rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        f3  = 3'($urandom); f7 = 7'($urandom);
        case ($urandom_range(0, 3))
          0: imm = int'($urandom_range(0, 8191)) - 4096;
          1: imm = edges[$urandom_range(0, 10)];
          2: imm = int'($urandom & 32'hfffff000);
          default: imm = int'($urandom);
        endcase
        m = model_encode(op, rd, rs1, rs2, f3, f7, imm);
        send(op, rd, rs1, rs2, f3, f7, imm, m[31:0], m[32], w);
      end
      finish_session("rand");
    end

    ready_mode = 0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
